// File: rtl/sine_wave_analyser.sv
// sine_wave_analyser
// Receive side of the sine generator. It finds rising midpoint crossings with hysteresis,
// measures the period in valid samples and reports lock, phase position and slope direction.
// Optional feature macro PEAK_TRACK_EN: when defined, the block also reports the peak and
// trough of the last complete period. When undefined, peak and trough are tied to zero.
module sine_wave_analyser #(
    parameter int SINE_SIZE  = 8,
    parameter int HYST       = 8,
    parameter int CNT_W      = 12,
    parameter int MAX_PERIOD = 4095
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sample_valid,
    input  logic [SINE_SIZE-1:0] sample,
    input  logic                 lock_clear,
    output logic                 locked,
    output logic [CNT_W-1:0]     period,
    output logic                 period_valid,
    output logic [CNT_W-1:0]     phase_count,
    output logic                 direction,
    output logic                 timeout,
    output logic [SINE_SIZE-1:0] peak,
    output logic [SINE_SIZE-1:0] trough
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_FIRST  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [SINE_SIZE-1:0] MID      = {1'b1, {(SINE_SIZE-1){1'b0}}};
    localparam logic [SINE_SIZE-1:0] ARM_TH   = MID - SINE_SIZE'(HYST);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MAX_PERIOD - 1);
    localparam logic [CNT_W-1:0]     CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]     CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]           state_r, state_n;
    logic [CNT_W-1:0]     cnt_r, cnt_n;
    logic [CNT_W-1:0]     period_r, period_n;
    logic                 period_valid_r, period_valid_n;
    logic                 timeout_r, timeout_n;
    logic                 locked_r, locked_n;
    logic                 armed_r, armed_n;
    logic [SINE_SIZE-1:0] prev_r, prev_n;
    logic                 direction_r, direction_n;
    logic                 cross_s;
    logic                 latch_s;

    // Crossing detect, slope tracking and period/lock state machine next-state logic.
    always_comb begin
        cross_s        = sample_valid & ~lock_clear & armed_r & (sample >= MID);
        state_n        = state_r;
        cnt_n          = cnt_r;
        period_n       = period_r;
        period_valid_n = 1'b0;
        timeout_n      = 1'b0;
        armed_n        = armed_r;
        prev_n         = prev_r;
        direction_n    = direction_r;
        latch_s        = 1'b0;
        if (lock_clear) begin
            // Restart the search; the sample offered this cycle is discarded entirely.
            state_n = ST_SEARCH;
            cnt_n   = CNT_ZERO;
            armed_n = 1'b0;
        end else if (sample_valid) begin
            prev_n = sample;
            if (sample < prev_r) begin
                direction_n = 1'b1;
            end else if (sample > prev_r) begin
                direction_n = 1'b0;
            end else begin
                direction_n = direction_r;
            end
            if (cross_s) begin
                armed_n = 1'b0;
            end else if (sample < ARM_TH) begin
                armed_n = 1'b1;
            end else begin
                armed_n = armed_r;
            end
            case (state_r)
                ST_SEARCH: begin
                    cnt_n = CNT_ZERO;
                    if (cross_s) begin
                        state_n = ST_FIRST;
                    end else begin
                        state_n = ST_SEARCH;
                    end
                end
                ST_FIRST, ST_LOCKED: begin
                    if (cross_s) begin
                        // A crossing on the would-be timeout sample still counts as a period.
                        state_n        = ST_LOCKED;
                        period_n       = cnt_r + CNT_ONE;
                        period_valid_n = 1'b1;
                        cnt_n          = CNT_ZERO;
                        latch_s        = 1'b1;
                    end else if (cnt_r == CNT_LAST) begin
                        state_n   = ST_SEARCH;
                        cnt_n     = CNT_ZERO;
                        timeout_n = (state_r == ST_LOCKED);
                    end else begin
                        cnt_n = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_n = ST_SEARCH;
                    cnt_n   = CNT_ZERO;
                end
            endcase
        end else begin
            state_n = state_r;
        end
        locked_n = (state_n == ST_LOCKED);
    end

    // Register all state and outputs; reset aborts any measurement in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= ST_SEARCH;
            cnt_r          <= CNT_ZERO;
            period_r       <= CNT_ZERO;
            period_valid_r <= 1'b0;
            timeout_r      <= 1'b0;
            locked_r       <= 1'b0;
            armed_r        <= 1'b0;
            prev_r         <= {SINE_SIZE{1'b0}};
            direction_r    <= 1'b0;
        end else begin
            state_r        <= state_n;
            cnt_r          <= cnt_n;
            period_r       <= period_n;
            period_valid_r <= period_valid_n;
            timeout_r      <= timeout_n;
            locked_r       <= locked_n;
            armed_r        <= armed_n;
            prev_r         <= prev_n;
            direction_r    <= direction_n;
        end
    end

    assign locked       = locked_r;
    assign period       = period_r;
    assign period_valid = period_valid_r;
    assign phase_count  = cnt_r;
    assign direction    = direction_r;
    assign timeout      = timeout_r;

`ifdef PEAK_TRACK_EN
    logic [SINE_SIZE-1:0] run_max_r, run_max_n;
    logic [SINE_SIZE-1:0] run_min_r, run_min_n;
    logic [SINE_SIZE-1:0] peak_r, peak_n;
    logic [SINE_SIZE-1:0] trough_r, trough_n;

    // Running extremes since the last crossing; a completed period publishes them.
    always_comb begin
        run_max_n = run_max_r;
        run_min_n = run_min_r;
        peak_n    = peak_r;
        trough_n  = trough_r;
        if (cross_s) begin
            if (latch_s) begin
                peak_n   = run_max_r;
                trough_n = run_min_r;
            end else begin
                peak_n   = peak_r;
                trough_n = trough_r;
            end
            run_max_n = sample;
            run_min_n = sample;
        end else if (sample_valid && !lock_clear) begin
            if (sample > run_max_r) begin
                run_max_n = sample;
            end else begin
                run_max_n = run_max_r;
            end
            if (sample < run_min_r) begin
                run_min_n = sample;
            end else begin
                run_min_n = run_min_r;
            end
        end else begin
            run_max_n = run_max_r;
        end
    end

    // Extreme-tracking registers; only reset clears the published values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_max_r <= {SINE_SIZE{1'b0}};
            run_min_r <= {SINE_SIZE{1'b0}};
            peak_r    <= {SINE_SIZE{1'b0}};
            trough_r  <= {SINE_SIZE{1'b0}};
        end else begin
            run_max_r <= run_max_n;
            run_min_r <= run_min_n;
            peak_r    <= peak_n;
            trough_r  <= trough_n;
        end
    end

    assign peak   = peak_r;
    assign trough = trough_r;
`else
    assign peak   = {SINE_SIZE{1'b0}};
    assign trough = {SINE_SIZE{1'b0}};
`endif

endmodule

// File: tb/tb_sine_wave_analyser.sv
// Directed self-checking bench for sine_wave_analyser (default parameters).
module tb_sine_wave_analyser;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [7:0]  sample = 8'd0;
    logic        lock_clear = 1'b0;
    logic        locked;
    logic [11:0] period;
    logic        period_valid;
    logic [11:0] phase_count;
    logic        direction;
    logic        timeout;
    logic [7:0]  peak;
    logic [7:0]  trough;

    int errors = 0;
    int checks = 0;
    int pv_seen;

    sine_wave_analyser dut (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .lock_clear   (lock_clear),
        .locked       (locked),
        .period       (period),
        .period_valid (period_valid),
        .phase_count  (phase_count),
        .direction    (direction),
        .timeout      (timeout),
        .peak         (peak),
        .trough       (trough)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] s, input logic clr);
        @(negedge clock);
        sample_valid = v;
        sample       = s;
        lock_clear   = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic feed(input int n, input logic [7:0] s);
        for (int i = 0; i < n; i++) step(1'b1, s, 1'b0);
    endtask

    task automatic triangle_period();
        for (int v = 0; v <= 255; v += 5) step(1'b1, 8'(v), 1'b0);
        for (int v = 250; v >= 5; v -= 5) step(1'b1, 8'(v), 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_phase", 32'(phase_count), 32'd0);
        chk("rst_dir", 32'(direction), 32'd0);
        chk("rst_pv", 32'(period_valid), 32'd0);
        chk("rst_to", 32'(timeout), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Square-ish wave 10x0 / 10x255: lock at the second rise with period 20
        feed(10, 8'd0);
        feed(10, 8'd255);
        chk("sq_first_phase", 32'(phase_count), 32'd9);
        chk("sq_first_locked", 32'(locked), 32'd0);
        chk("sq_dir_rise", 32'(direction), 32'd0);
        feed(10, 8'd0);
        chk("sq_phase19", 32'(phase_count), 32'd19);
        chk("sq_dir_fall", 32'(direction), 32'd1);
        feed(1, 8'd255);
        chk("sq_pv", 32'(period_valid), 32'd1);
        chk("sq_period", 32'(period), 32'd20);
        chk("sq_locked", 32'(locked), 32'd1);
        chk("sq_phase0", 32'(phase_count), 32'd0);
        feed(1, 8'd255);
        chk("sq_pv_pulse", 32'(period_valid), 32'd0);
        chk("sq_phase1", 32'(phase_count), 32'd1);
        chk("sq_peak_off", 32'(peak), 32'd0);

        // Invalid cycle: nothing moves
        step(1'b0, 8'd0, 1'b0);
        chk("inv_phase", 32'(phase_count), 32'd1);
        chk("inv_dir", 32'(direction), 32'd0);

        // Hold 255 until timeout out of LOCKED
        feed(4093, 8'd255);
        chk("to_phase4094", 32'(phase_count), 32'd4094);
        chk("to_pre_locked", 32'(locked), 32'd1);
        chk("to_pre_pulse", 32'(timeout), 32'd0);
        feed(1, 8'd255);
        chk("to_pulse", 32'(timeout), 32'd1);
        chk("to_locked", 32'(locked), 32'd0);
        chk("to_phase0", 32'(phase_count), 32'd0);
        chk("to_period_kept", 32'(period), 32'd20);
        feed(1, 8'd255);
        chk("to_pulse_end", 32'(timeout), 32'd0);

        // Crossing exactly on the timeout sample wins: period 4095
        feed(10, 8'd0);
        feed(1, 8'd255);
        feed(4094, 8'd0);
        chk("xw_phase", 32'(phase_count), 32'd4094);
        feed(1, 8'd255);
        chk("xw_pv", 32'(period_valid), 32'd1);
        chk("xw_period", 32'(period), 32'd4095);
        chk("xw_no_to", 32'(timeout), 32'd0);
        chk("xw_locked", 32'(locked), 32'd1);

        // lock_clear beats a simultaneous crossing sample
        feed(5, 8'd0);
        chk("lc_pre_phase", 32'(phase_count), 32'd5);
        step(1'b1, 8'd255, 1'b1);
        chk("lc_pv", 32'(period_valid), 32'd0);
        chk("lc_locked", 32'(locked), 32'd0);
        chk("lc_phase", 32'(phase_count), 32'd0);
        chk("lc_period_kept", 32'(period), 32'd4095);
        chk("lc_dir_held", 32'(direction), 32'd1);
        feed(1, 8'd255);
        chk("lc_disarmed_pv", 32'(period_valid), 32'd0);
        chk("lc_dir_after", 32'(direction), 32'd0);
        chk("lc_phase_search", 32'(phase_count), 32'd0);

        // Hysteresis band: 125/129 never arms
        pv_seen = 0;
        for (int i = 0; i < 100; i++) begin
            feed(1, 8'd125);
            if (period_valid) pv_seen++;
            feed(1, 8'd129);
            if (period_valid) pv_seen++;
        end
        chk("hy_pv_count", 32'(pv_seen), 32'd0);
        chk("hy_locked", 32'(locked), 32'd0);
        chk("hy_phase", 32'(phase_count), 32'd0);

        // Threshold edges: 119 arms, 128 crosses, 120 does not arm
        feed(1, 8'd119);
        feed(1, 8'd128);
        chk("th_cross_phase", 32'(phase_count), 32'd0);
        feed(1, 8'd120);
        feed(1, 8'd128);
        chk("th_no_rearm", 32'(phase_count), 32'd2);
        chk("th_locked", 32'(locked), 32'd0);
        feed(1, 8'd0);
        feed(1, 8'd255);
        chk("th_period4", 32'(period), 32'd4);
        chk("th_locked1", 32'(locked), 32'd1);
        feed(1, 8'd0);

        // Asynchronous reset while LOCKED clears outputs immediately
        @(negedge clock);
        sample_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_locked", 32'(locked), 32'd0);
        chk("ar_period", 32'(period), 32'd0);
        chk("ar_phase", 32'(phase_count), 32'd0);
        chk("ar_dir", 32'(direction), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        feed(1, 8'd255);
        chk("ar_no_cross", 32'(period_valid), 32'd0);
        chk("ar_search_phase", 32'(phase_count), 32'd0);

        // Triangle 0..255..0 step 5: period 102, extremes 255/0
        triangle_period();
        triangle_period();
        triangle_period();
        chk("tri_period", 32'(period), 32'd102);
        chk("tri_locked", 32'(locked), 32'd1);
        chk("tri_phase", 32'(phase_count), 32'd75);
`ifdef PEAK_TRACK_EN
        chk("tri_peak", 32'(peak), 32'd255);
        chk("tri_trough", 32'(trough), 32'd0);
`else
        chk("tri_peak_off", 32'(peak), 32'd0);
        chk("tri_trough_off", 32'(trough), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
